alu_muldiv: RTL

Parametrised execute-stage ALU for the RV32I/RV64I datapath. It adds the M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) alongside the base integer operations. Base operations complete in one cycle. M operations run a fixed-latency iterative shift-add / restoring-division engine behind a valid/ready handshake, which the pipeline uses to stall issue.

---
 rtl/alu_muldiv_if.sv | 28 ++
 rtl/alu_muldiv.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_if.sv
// Handshake and operand/result bundle between the issue stage and the execute ALU.
// The master drives operations and kill; the slave returns the handshake and the result.
interface alu_muldiv_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic            kill;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic [1:0]      alu_op;
    logic            out_valid;
    logic [XLEN-1:0] C;
    logic            zero;
    logic            busy;

    modport master (
        output in_valid, kill, A, B, funct7, funct3, alu_op,
        input  in_ready, out_valid, C, zero, busy
    );

    modport slave (
        input  in_valid, kill, A, B, funct7, funct3, alu_op,
        output in_ready, out_valid, C, zero, busy
    );
endinterface

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: single-cycle base integer ops plus an iterative M-extension engine
// (shift-add multiply, restoring divide) behind a valid/ready handshake.
module alu_muldiv #(
    parameter int XLEN = 32
) (
    input logic         clk,
    input logic         rst,
    alu_muldiv_if.slave bus
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [SHW:0]    CNT_LAST = (SHW+1)'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        r_state;
    logic [SHW:0]      r_cnt;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_ma, r_mb, r_c;
    logic              r_sa, r_sb, r_out_valid;
    logic [2:0]        r_f3;

    logic              w_idle, w_accept, w_a_signed, w_b_signed, w_sa, w_sb;
    logic [SHW-1:0]    w_shamt;
    logic [XLEN-1:0]   w_base, w_ma, w_mb, w_m_result;
    logic [XLEN:0]     w_mul_sum, w_div_shift, w_div_diff;
    logic [2*XLEN-1:0] w_acc_next, w_prod;
    logic [XLEN-1:0]   w_quo, w_rem, w_a_orig;
    logic              w_b_zero, w_ovf;

    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = w_idle & bus.in_valid & ~bus.kill;
    assign w_shamt  = bus.B[SHW-1:0];

    // Signedness by funct3: MUL/MULH/DIV/REM both signed, MULHSU only A, the rest unsigned.
    assign w_a_signed = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
    assign w_b_signed = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
    assign w_sa = w_a_signed & bus.A[XLEN-1];
    assign w_sb = w_b_signed & bus.B[XLEN-1];
    assign w_ma = w_sa ? -bus.A : bus.A;
    assign w_mb = w_sb ? -bus.B : bus.B;

    always_comb begin
        // NOTE: default first so every path assigns w_base and no latch is inferred.
        w_base = bus.A + bus.B;
        case (bus.alu_op)
            2'b00: w_base = bus.A + bus.B;
            2'b01: w_base = bus.A - bus.B;
            default: begin
                case (bus.funct3)
                    3'b000: w_base = bus.funct7[5] ? bus.A - bus.B : bus.A + bus.B;
                    3'b001: w_base = bus.A << w_shamt;
                    3'b010: w_base = {{(XLEN-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
                    3'b011: w_base = {{(XLEN-1){1'b0}}, bus.A < bus.B};
                    3'b100: w_base = bus.A ^ bus.B;
                    3'b101: w_base = bus.funct7[5] ? $unsigned($signed(bus.A) >>> w_shamt)
                                                   : bus.A >> w_shamt;
                    3'b110: w_base = bus.A | bus.B;
                    default: w_base = bus.A & bus.B;
                endcase
            end
        endcase
    end

    // Multiply: acc = {partial product, multiplier}; divide: acc = {remainder, dividend/quotient}.
    assign w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_ma} : '0);
    assign w_div_shift = r_acc[2*XLEN-1:XLEN-1];
    assign w_div_diff  = w_div_shift - {1'b0, r_mb};
    assign w_acc_next  = r_f3[2]
        ? {(w_div_diff[XLEN] ? w_div_shift[XLEN-1:0] : w_div_diff[XLEN-1:0]),
           r_acc[XLEN-2:0], ~w_div_diff[XLEN]}
        : {w_mul_sum, r_acc[XLEN-1:1]};

    assign w_prod   = (r_sa ^ r_sb) ? -r_acc : r_acc;
    assign w_quo    = (r_sa ^ r_sb) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem    = r_sa ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    assign w_a_orig = r_sa ? -r_ma : r_ma;
    assign w_b_zero = (r_mb == '0);
    assign w_ovf    = r_sa & r_sb & (r_ma == MIN_NEG) & (r_mb == XLEN'(1));

    always_comb begin
        w_m_result = w_prod[XLEN-1:0];
        case (r_f3)
            3'b000:         w_m_result = w_prod[XLEN-1:0];
            3'b100, 3'b101: w_m_result = w_b_zero ? '1 : (w_ovf ? MIN_NEG : w_quo);
            3'b110, 3'b111: w_m_result = w_b_zero ? w_a_orig : (w_ovf ? '0 : w_rem);
            default:        w_m_result = w_prod[2*XLEN-1:XLEN];
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_ma        <= '0;
            r_mb        <= '0;
            r_sa        <= 1'b0;
            r_sb        <= 1'b0;
            r_f3        <= '0;
            r_c         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (bus.alu_op == 2'b11) begin
                            r_ma    <= w_ma;
                            r_mb    <= w_mb;
                            r_sa    <= w_sa;
                            r_sb    <= w_sb;
                            r_f3    <= bus.funct3;
                            r_acc   <= {{XLEN{1'b0}}, (bus.funct3[2] ? w_ma : w_mb)};
                            r_cnt   <= '0;
                            r_state <= S_CALC;
                        end else begin
                            r_c         <= w_base;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    if (bus.kill) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + (SHW+1)'(1);
                        if (r_cnt == CNT_LAST) r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    if (!bus.kill) begin
                        r_c         <= w_m_result;
                        r_out_valid <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_idle;
    assign bus.busy      = ~w_idle;
    assign bus.out_valid = r_out_valid;
    assign bus.C         = r_c;
    assign bus.zero      = (r_c == '0);
endmodule
